// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the execute-stage units: operand width,
// M-extension funct3 encodings and the multiply/divide control states.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  localparam logic [4:0] MDU_LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted = {rem, dividend_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low XLEN bits of the wrapped difference are exact.
  assign diff     = shifted[XLEN-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/rtype_mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or
// restoring divide on operand magnitudes, with sign fix-up on the last step.
module rtype_mdu
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd
);

  mdu_state_e      state_q, state_d;
  logic [4:0]      count_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, lo_q; // product halves, or remainder / dividend-quotient
  logic            neg_res_q, neg_rem_q, hold_q;

  // ---------------- issue-side decode ----------------
  logic            accept, s1_in, s2_in, div_zero, overflow, special;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

  assign accept   = in_valid && in_ready;
  assign s1_in    = rs1_data[XLEN-1] && (funct3 == MDU_MULH || funct3 == MDU_MULHSU ||
                                         funct3 == MDU_DIV  || funct3 == MDU_REM);
  assign s2_in    = rs2_data[XLEN-1] && (funct3 == MDU_MULH || funct3 == MDU_DIV ||
                                         funct3 == MDU_REM);
  assign a_mag_in = s1_in ? -rs1_data : rs1_data;
  assign b_mag_in = s2_in ? -rs2_data : rs2_data;

  assign div_zero = funct3[2] && (rs2_data == '0);
  assign overflow = (funct3 == MDU_DIV || funct3 == MDU_REM) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = div_zero || overflow;

  // funct3[1] separates the remainder forms from the quotient forms.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? rs1_data : '1;
    else
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem_next, step_hi, step_lo;
  logic              div_q_bit;
  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result_sel;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  mdu_div_step u_div_step (
    .rem          (hi_q),
    .dividend_bit (lo_q[XLEN-1]),
    .divisor      (opnd_q),
    .rem_next     (div_rem_next),
    .q_bit        (div_q_bit)
  );

  assign step_hi = op_q[2] ? div_rem_next : mul_sum[XLEN:1];
  assign step_lo = op_q[2] ? {lo_q[XLEN-2:0], div_q_bit} : {mul_sum[0], lo_q[XLEN-1:1]};

  assign product  = {step_hi, step_lo};
  assign prod_fix = neg_res_q ? -product : product;
  assign quo_fix  = neg_res_q ? -step_lo : step_lo;
  assign rem_fix  = neg_rem_q ? -step_hi : step_hi;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    result_sel = quo_fix;
    case (op_q)
      MDU_MUL:                        result_sel = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result_sel = prod_fix[2*XLEN-1:XLEN];
      MDU_REM, MDU_REMU:              result_sel = rem_fix;
      default:                        result_sel = quo_fix;
    endcase
  end

  // ---------------- control FSM ----------------
  assign in_ready  = (state_q == IDLE);
  // Special-case results sit in DONE for one settle cycle before being offered.
  assign out_valid = (state_q == DONE) && !hold_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (count_q == MDU_LAST_STEP) state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      op_q      <= MDU_MUL;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hold_q    <= 1'b0;
      result    <= '0;
      out_rd    <= '0;
    end else begin
      hold_q <= 1'b0;
      if (accept) begin
        op_q      <= funct3;
        out_rd    <= rd_addr;
        count_q   <= '0;
        neg_res_q <= s1_in ^ s2_in;
        neg_rem_q <= s1_in;
        hold_q    <= special;
        hi_q      <= '0;
        lo_q      <= funct3[2] ? a_mag_in : b_mag_in;
        opnd_q    <= funct3[2] ? b_mag_in : a_mag_in;
        if (special) result <= special_res;
      end else if (state_q == CALC) begin
        hi_q <= step_hi;
        lo_q <= step_lo;
        if (count_q == MDU_LAST_STEP) result <= result_sel;
        else                          count_q <= count_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtype_mdu.sv
// Self-checking bench for rtype_mdu: directed M-extension cases, handshake
// timing, reset abort and randomized operations against a 64-bit arithmetic model.
module tb_rtype_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rtype_mdu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_rd    (out_rd)
  );

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  // Issue one operation, wait (bounded) for out_valid, then complete the handshake.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] ord, output int lat);
    @(negedge clk);
    in_valid = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    res = result;
    ord = out_rd;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] res, exp_res;
    logic [4:0]  ord;
    int          lat, exp_lat;
    exp_res = ref_result(f, a, b);
    exp_lat = ref_latency(f, a, b);
    run_op(f, a, b, rd, res, ord, lat);
    n_checks++;
    if (res !== exp_res)
      $display("FAIL %s result: got %08h expected %08h (f=%0d a=%08h b=%08h)", name, res, exp_res, f, a, b);
    else n_pass++;
    n_checks++;
    if (ord !== rd) $display("FAIL %s out_rd: got %0d expected %0d", name, ord, rd);
    else n_pass++;
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s post-handshake: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || out_rd !== 5'd0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%08h out_rd=%0d expected 1/0/0/0",
               in_ready, out_valid, result, out_rd);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_mul();
    check_op("mul_7x_neg3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check_op("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    check_op("mulhu_max_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    check_op("mulhsu_max_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
  endtask

  task automatic test_div();
    check_op("div_neg7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8);
    check_op("rem_neg7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9);
    check_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd10);
    check_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd11);
    check_op("div_7_neg2", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd12);
    check_op("rem_7_neg2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd13);
  endtask

  task automatic test_special();
    check_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd14);
    check_op("remu_5_0", 3'd7, 32'd5, 32'd0, 5'd15);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res;
    int          lat;
    bit          bad_hold;
    exp_res = ref_result(3'd5, 32'd1000, 32'd3);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd21;
    out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    n_checks++;
    if (lat !== 32) $display("FAIL bp_latency: got %0d expected 32", lat);
    else n_pass++;
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd3;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_res || out_rd !== 5'd21)
        bad_hold = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    n_checks++;
    if (bad_hold || result !== exp_res || out_rd !== 5'd21)
      $display("FAIL bp_hold: result=%08h out_rd=%0d expected %08h/21 stable, valid held, not ready",
               result, out_rd, exp_res);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_no_accept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bit saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd0; rs1_data = 32'd123; rs2_data = 32'd456; rd_addr = 5'd4;
    out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_calc_during: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (saw_valid || in_ready !== 1'b1)
      $display("FAIL rst_mid_calc_after: saw_valid=%b in_ready=%b expected 0/1", saw_valid, in_ready);
    else n_pass++;
    check_op("mulhu_3x5_after_rst", 3'd3, 32'd3, 32'd5, 5'd1);
  endtask

  task automatic measure_spacing(input string name, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input int exp_gap);
    int acc_cyc[2];
    int n_acc, cyc;
    n_acc = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    @(negedge clk);
    in_valid = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_addr = 5'd2;
    out_ready = 1'b1;
    while (n_acc < 2 && cyc < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 2) begin @(posedge clk); #1; in_valid = 1'b0; end
      end
      cyc++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !in_ready; i++) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != exp_gap)
      $display("FAIL %s spacing: accepts=%0d gap=%0d expected 2/%0d", name, n_acc,
               acc_cyc[1] - acc_cyc[0], exp_gap);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    measure_spacing("b2b_normal", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 34);
    measure_spacing("b2b_special", 3'd5, 32'd77, 32'd0, 3);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      check_op("random", f, a, b, rd);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
